// File: rtl/branch_resolve_ctrl_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl_if
//   Bundle between the EX stage and the branch resolution controller.
//   master : EX-stage side. Drives the instruction and operands and receives
//            the redirect, flush and stall controls.
//   slave  : branch_resolve_ctrl. Receives the instruction and operands and
//            drives the controls.
//   Signals:
//     ex_valid, ex_br_ctrl[2:0], ex_jump, ex_rs1, ex_rs2, ex_target,
//     opnd_ready                                   (EX -> controller)
//     stall, redirect_valid, redirect_pc, flush, busy
//     stat_br_cnt, stat_taken_cnt (BR_STATS_EN)    (controller -> EX)
//   Optional feature macro: BR_STATS_EN adds the statistics counters.
// ----------------------------------------------------------------------------
interface branch_resolve_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            ex_valid;
  logic [2:0]      ex_br_ctrl;
  logic            ex_jump;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_target;
  logic            opnd_ready;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            busy;
`ifdef BR_STATS_EN
  logic [CNT_W-1:0] stat_br_cnt;
  logic [CNT_W-1:0] stat_taken_cnt;
`endif

  modport master (
    output ex_valid, ex_br_ctrl, ex_jump, ex_rs1, ex_rs2, ex_target,
           opnd_ready,
`ifdef BR_STATS_EN
    input  stat_br_cnt, stat_taken_cnt,
`endif
    input  stall, redirect_valid, redirect_pc, flush, busy
  );

  modport slave (
    input  ex_valid, ex_br_ctrl, ex_jump, ex_rs1, ex_rs2, ex_target,
           opnd_ready,
`ifdef BR_STATS_EN
    output stat_br_cnt, stat_taken_cnt,
`endif
    output stall, redirect_valid, redirect_pc, flush, busy
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl
//   EX-stage branch/jump resolution controller. Evaluates the branch condition
//   on the forwarded operands, stalls the front end while the operands are not
//   ready, issues a one-cycle PC redirect for taken branches/jumps and then
//   holds flush high for FLUSH_CYCLES cycles to kill wrong-path work.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset
//     bus  : branch_resolve_ctrl_if.slave (EX inputs, control outputs)
//   Parameters: XLEN (datapath width), FLUSH_CYCLES (1..15),
//               CNT_W (statistics counter width).
//   Optional feature macro: BR_STATS_EN enables the resolved/taken counters.
// ----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The counter is loaded with FLUSH_CYCLES-1 so the FLUSH state, including
  // the cycle it is entered, lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_flush;
  logic            r_busy;

  logic [XLEN-1:0] w_diff;
  logic            w_is_br;
  logic            w_req;
  logic            w_taken;
  logic            w_stall;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_taken = 1'b0;
    w_stall = 1'b0;

    // Plain modular subtraction: the sign bit of the wrapped difference is
    // the less-than result, with no overflow correction, matching the EX
    // comparator bit for bit.
    w_diff  = bus.ex_rs1 - bus.ex_rs2;
    w_is_br = (bus.ex_br_ctrl >= 3'd1) && (bus.ex_br_ctrl <= 3'd4);
    w_req   = bus.ex_valid & (bus.ex_jump | w_is_br);

    case (bus.ex_br_ctrl)
      3'd1:    w_taken = (w_diff == '0);
      3'd2:    w_taken = (w_diff != '0);
      3'd3:    w_taken = w_diff[XLEN-1];
      3'd4:    w_taken = ~w_diff[XLEN-1];
      default: w_taken = 1'b0;
    endcase
    if (bus.ex_jump) w_taken = 1'b1;

    // In HOLD the stall keeps the EX instruction in place, so only operand
    // readiness matters there. FLUSH never stalls: EX holds wrong-path work.
    if (!rst) begin
      case (r_state)
        IDLE:    w_stall = w_req & ~bus.opnd_ready;
        HOLD:    w_stall = ~bus.opnd_ready;
        default: w_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_redirect_valid <= 1'b0;
      case (r_state)
        IDLE, HOLD: begin
          if (w_stall) begin
            r_state <= HOLD;
            r_busy  <= 1'b1;
            r_flush <= 1'b0;
          end else if (w_req && w_taken) begin
            r_state          <= FLUSH;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= bus.ex_target;
            r_flush          <= 1'b1;
            r_busy           <= 1'b1;
            r_cnt            <= FLUSH_INIT;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_flush <= 1'b0;
          end
        end
        FLUSH: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall          = w_stall;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush          = r_flush;
  assign bus.busy           = r_busy;

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] r_stat_br_cnt;
  logic [CNT_W-1:0] r_stat_taken_cnt;
  logic             w_resolve;

  // A resolution is a request evaluated with ready operands outside FLUSH.
  assign w_resolve = (r_state != FLUSH) & w_req & bus.opnd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br_cnt    <= '0;
      r_stat_taken_cnt <= '0;
    end else if (w_resolve) begin
      r_stat_br_cnt <= r_stat_br_cnt + CNT_W'(1);
      if (w_taken) r_stat_taken_cnt <= r_stat_taken_cnt + CNT_W'(1);
    end
  end

  assign bus.stat_br_cnt    = r_stat_br_cnt;
  assign bus.stat_taken_cnt = r_stat_taken_cnt;
`endif

endmodule
